mon_commit_serializer: RTL and testbench
========================================

# mon_commit_serializer

Commit-stream serializer between the ROB retire ports and the single-channel monitor/RVFI checker. It accepts up to CHANNELS retirement records per cycle, compacts the valid lanes, buffers them in a power-of-two FIFO, and emits one record per cycle in retire order under a valid/ready handshake. It also checks that consecutive emitted `order` values are contiguous and raises a sticky error flag on any gap.

## Interface

Parameters:
- CHANNELS, 2, retire lanes per cycle; 1..4.
- DEPTH, 8, FIFO entries; power of two, at least 2*CHANNELS.
- PAYLOAD_W, 32, opaque per-record payload width (inst, pc, rd data, etc., packed by the instantiator).

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  CHANNELS  per-lane retire valid; lanes may be sparse.
- in_order  in  CHANNELS*64  per-lane order; lane i occupies bits [64*i+63:64*i].
- in_payload  in  CHANNELS*PAYLOAD_W  per-lane payload, same lane packing.
- in_ready  out  1  group accept; all valid lanes are taken together.
- out_valid  out  1  head record present.
- out_order  out  64  head order; 0 when out_valid=0.
- out_payload  out  PAYLOAD_W  head payload; 0 when out_valid=0.
- out_ready  in  1  consumer accept.
- count  out  $clog2(DEPTH)+1  current occupancy.
- order_error  out  1  sticky contiguity violation.

## Operation

- Push fires when in_ready=1 and in_valid is nonzero. Valid lanes are compacted in ascending lane index and written to consecutive slots starting at wr_ptr. wr_ptr then advances by popcount(in_valid).
- in_ready = (DEPTH - count) >= CHANNELS. It is computed from registered count only, with no combinational path from out_ready.
- A push offered while in_ready=0 is ignored; nothing is written.
- Pop fires when out_valid=1 and out_ready=1. rd_ptr then advances by 1.
- out_valid = (count != 0). The out_* signals come from the slot at rd_ptr.
- count_next = count + pushed - popped. Simultaneous push and pop is legal in every state, including full-minus-CHANNELS and count=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Full and empty are resolved by count, not by pointer compare.
- Contiguity checker:
  - Registers: seen_first (1b) and expected (64b).
  - On the first pop after reset: seen_first←1 and expected←out_order+1. No check is made.
  - On each later pop: if out_order != expected, then order_error←1. Always expected←out_order+1, with 64-bit wrap.
  - order_error stays at 1 until reset. The FIFO keeps running after an error.
- Within one pushed group, lane order is not checked at enqueue; only the dequeued stream is checked.

## Timing

- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, seen_first=0, expected=0, order_error=0.
  - Outputs during reset: out_valid=0, out_order=0, out_payload=0, in_ready=1.
  - FIFO storage is not reset.
  - A reset mid-stream discards all buffered records immediately.
- Latency: a record pushed on edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Throughput: up to CHANNELS records in, 1 record out per cycle. The monitor drain is the bottleneck by design.
- in_ready reflects the pre-edge count. A pop in cycle N frees space seen by in_ready only in cycle N+1.
- order_error rises the cycle after the offending pop edge.
- Outputs are stable while out_valid=1 and out_ready=0.

## Test plan

All scenarios use CHANNELS=2, DEPTH=8, PAYLOAD_W=32.
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_order=0, count=0, in_ready=1, order_error=0. Deassert with no push -> all outputs unchanged.
- Dual push: in_valid=2'b11, orders 0/1, payloads A0/A1, out_ready=0 -> next cycle count=2, out_valid=1, out_order=0, out_payload=A0. After out_ready=1 for two cycles -> orders 0 then 1, count=0.
- Sparse lanes: in_valid=2'b10, lane1 order=5, payload=B5 -> count=1, out_order=5, out_payload=B5. Lane 0 data is never emitted.
- Full/backpressure, with out_ready=0:
  - Four dual pushes -> count=8, in_ready=0. A fifth push is ignored and count stays 8.
  - Pop once -> count=7, in_ready=0.
  - Pop again -> count=6, in_ready=1 the following cycle.
  - The output sequence continues without loss.
- Wrap and simultaneous traffic: stream orders 0..39 with random lane masks and out_ready toggling every cycle -> emitted orders exactly 0..39, both pointers wrap at least 4 times, order_error=0.
- Gap and reset: push orders 0, 1, 3 and drain:
  - order_error=0 after pops of 0 and 1; order_error=1 the cycle after 3 pops, and it remains 1.
  - Assert rst_n mid-stream with count=3 -> count=0, out_valid=0, order_error=0 immediately.

Source files
------------

// File: rtl/mon_commit_serializer_if.sv
// Commit-stream handshake bundle: multi-lane retire side in, single-record monitor side out.
interface mon_commit_serializer_if #(
  parameter int CHANNELS  = 2,
  parameter int PAYLOAD_W = 32
);
  logic [CHANNELS-1:0]           in_valid;
  logic [CHANNELS*64-1:0]        in_order;
  logic [CHANNELS*PAYLOAD_W-1:0] in_payload;
  logic                          in_ready;
  logic                          out_valid;
  logic [63:0]                   out_order;
  logic [PAYLOAD_W-1:0]          out_payload;
  logic                          out_ready;

  // Serializer side: takes retire lanes, drives the monitor stream.
  modport slave (
    input  in_valid, in_order, in_payload, out_ready,
    output in_ready, out_valid, out_order, out_payload
  );

  // Environment side: ROB retire producer plus monitor consumer.
  modport master (
    output in_valid, in_order, in_payload, out_ready,
    input  in_ready, out_valid, out_order, out_payload
  );
endinterface

// File: rtl/mon_commit_serializer.sv
// Compacts up to CHANNELS retire records per cycle into a FIFO and replays
// them one per cycle to the monitor, flagging any gap in the emitted order.
module mon_commit_serializer #(
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mon_commit_serializer_if.slave   bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     order_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]          r_ord_mem [DEPTH];
  logic [PAYLOAD_W-1:0] r_pay_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_seen_first;
  logic [63:0]   r_expected;
  logic          r_order_error;

  logic [AW-1:0] w_slot [CHANNELS];
  logic [CW-1:0] w_npush;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_head_order;

  // Destination slot per lane: wr_ptr plus the number of valid lanes below it.
  always_comb begin
    w_npush = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_slot[i] = r_wr_ptr + w_npush[AW-1:0];
      if (bus.in_valid[i]) w_npush = w_npush + CW'(1);
    end
  end

  // Space check uses registered count only, so out_ready never reaches in_ready.
  assign w_in_ready   = (r_count <= CW'(DEPTH - CHANNELS));
  assign w_out_valid  = (r_count != '0);
  assign w_push       = w_in_ready && (|bus.in_valid);
  assign w_pop        = w_out_valid && bus.out_ready;
  assign w_head_order = r_ord_mem[r_rd_ptr];

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_order   = w_out_valid ? w_head_order : '0;
  assign bus.out_payload = w_out_valid ? r_pay_mem[r_rd_ptr] : '0;
  assign count           = r_count;
  assign order_error     = r_order_error;

  // Record storage; deliberately not reset, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_push && bus.in_valid[i]) begin
        r_ord_mem[w_slot[i]] <= bus.in_order[64*i +: 64];
        r_pay_mem[w_slot[i]] <= bus.in_payload[PAYLOAD_W*i +: PAYLOAD_W];
      end
    end
  end

  // Pointers and occupancy; full/empty come from count, pointers just wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + w_npush[AW-1:0];
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (w_push ? w_npush : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
    end
  end

  // Contiguity checker on the emitted stream; the first pop only seeds expected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_first  <= 1'b0;
      r_expected    <= '0;
      r_order_error <= 1'b0;
    end else if (w_pop) begin
      r_seen_first <= 1'b1;
      r_expected   <= w_head_order + 64'd1;
      if (r_seen_first && (w_head_order != r_expected)) r_order_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mon_commit_serializer.sv
// Directed bench for mon_commit_serializer with a queue scoreboard and
// a reference model of occupancy and the order-contiguity checker.
module tb_mon_commit_serializer;
  localparam int CH = 2;
  localparam int DP = 8;
  localparam int PW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count;
  logic       order_error;

  mon_commit_serializer_if #(.CHANNELS(CH), .PAYLOAD_W(PW)) bus();

  mon_commit_serializer #(.CHANNELS(CH), .DEPTH(DP), .PAYLOAD_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .count       (count),
    .order_error (order_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] o;
    logic [31:0] p;
  } rec_t;

  rec_t        q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  logic        m_seen   = 1'b0;
  logic [63:0] m_exp    = '0;
  logic        m_err    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [63:0] o0, input logic [63:0] o1,
                       input logic [31:0] p0, input logic [31:0] p1);
    bus.in_valid   = m;
    bus.in_order   = {o1, o0};
    bus.in_payload = {p1, p0};
  endtask

  task automatic model_clear();
    q.delete();
    m_seen = 1'b0;
    m_exp  = '0;
    m_err  = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    int   sz;
    logic acc;
    @(negedge clk);
    sz = q.size();
    chk("count", 64'(count), 64'(sz));
    chk("in_ready", 64'(bus.in_ready), 64'(sz <= DP - CH));
    chk("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    chk("order_error", 64'(order_error), 64'(m_err));
    if (sz != 0) begin
      chk("out_order", bus.out_order, q[0].o);
      chk("out_payload", 64'(bus.out_payload), 64'(q[0].p));
    end else begin
      chk("out_order_idle", bus.out_order, 64'd0);
      chk("out_payload_idle", 64'(bus.out_payload), 64'd0);
    end
    acc = (sz <= DP - CH) && (bus.in_valid != '0);
    if (sz != 0 && bus.out_ready) begin
      if (m_seen && q[0].o != m_exp) m_err = 1'b1;
      m_seen = 1'b1;
      m_exp  = q[0].o + 64'd1;
      void'(q.pop_front());
      n_pops++;
    end
    if (acc) begin
      for (int k = 0; k < CH; k++)
        if (bus.in_valid[k]) q.push_back('{o: bus.in_order[64*k +: 64], p: bus.in_payload[32*k +: 32]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] nxt;
    logic [1:0]  m;
    logic [63:0] o0, o1;
    int          pops0;
    logic        done;

    // Reset held with random inputs.
    bus.out_ready = 1'($urandom);
    drive(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom);
    repeat (3) begin
      @(negedge clk);
      chk("rh_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rh_out_order", bus.out_order, 64'd0);
      chk("rh_count", 64'(count), 64'd0);
      chk("rh_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rh_order_error", 64'(order_error), 64'd0);
      drive(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom);
    end
    drive(2'b00, '0, '0, '0, '0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) tick();

    // Dual push then drain.
    drive(2'b11, 64'd0, 64'd1, 32'hA0, 32'hA1);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    chk("dual_count", 64'(count), 64'd2);
    chk("dual_head", bus.out_order, 64'd0);
    chk("dual_pay", 64'(bus.out_payload), 64'hA0);
    tick();
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("dual_drained", 64'(count), 64'd0);
    tick();

    // Sparse lane: only lane 1 valid.
    do_reset();
    bus.out_ready = 1'b0;
    drive(2'b10, 64'd77, 64'd5, 32'hDEAD, 32'hB5);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    chk("sparse_count", 64'(count), 64'd1);
    chk("sparse_order", bus.out_order, 64'd5);
    chk("sparse_pay", 64'(bus.out_payload), 64'hB5);
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // Full and backpressure.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 64'(2*i), 64'(2*i+1), 32'h100 + 32'(2*i), 32'h100 + 32'(2*i+1));
      tick();
    end
    drive(2'b00, '0, '0, '0, '0);
    chk("full_count", 64'(count), 64'd8);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pop1_count", 64'(count), 64'd7);
    chk("pop1_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pop2_count", 64'(count), 64'd6);
    chk("pop2_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    drive(2'b11, 64'd8, 64'd9, 32'h108, 32'h109);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    repeat (10) tick();
    chk("full_drain_err", 64'(order_error), 64'd0);

    // Wrap with random lane masks and toggling out_ready.
    do_reset();
    nxt = 0;
    pops0 = n_pops;
    done = 1'b0;
    bus.out_ready = 1'b0;
    for (int it = 0; it < 400 && !done; it++) begin
      m = (nxt >= 40) ? 2'b00 : 2'($urandom_range(0, 3));
      if (nxt == 39 && m == 2'b11) m = 2'b01;
      o0 = m[0] ? nxt : {$urandom, $urandom};
      o1 = m[1] ? (nxt + (m[0] ? 64'd1 : 64'd0)) : {$urandom, $urandom};
      drive(m, o0, o1, 32'(o0) ^ 32'hC0DE0000, 32'(o1) ^ 32'hC0DE0000);
      if (m != 2'b00 && q.size() <= DP - CH) nxt = nxt + 64'($countones(m));
      bus.out_ready = ~bus.out_ready;
      tick();
      done = (nxt == 40) && (q.size() == 0);
    end
    drive(2'b00, '0, '0, '0, '0);
    chk("wrap_done", 64'(done), 64'd1);
    chk("wrap_pops", 64'(n_pops - pops0), 64'd40);
    chk("wrap_err", 64'(order_error), 64'd0);

    // Gap in order stream.
    do_reset();
    bus.out_ready = 1'b0;
    drive(2'b11, 64'd0, 64'd1, 32'hC0, 32'hC1);
    tick();
    drive(2'b01, 64'd3, 64'd0, 32'hC3, 32'h0);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("gap_ok_after_two", 64'(order_error), 64'd0);
    tick();
    chk("gap_err_set", 64'(order_error), 64'd1);
    bus.out_ready = 1'b0;
    drive(2'b11, 64'd10, 64'd11, 32'hD0, 32'hD1);
    tick();
    drive(2'b01, 64'd12, 64'd0, 32'hD2, 32'h0);
    tick();
    drive(2'b00, '0, '0, '0, '0);
    chk("gap_err_sticky", 64'(order_error), 64'd1);
    chk("mid_count_pre", 64'(count), 64'd3);

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_order_error", 64'(order_error), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
